inst_fetch: RTL and testbench

Instruction-fetch stage fed by the PC register stage. Each fetch latches the current PC and issues a request/acknowledge read to instruction memory, which may insert any number of wait states. The fetched word, its PC and PC+4 go to decode through a valid/ready slot that has a one-entry skid buffer. The block also produces the stall that freezes the PC stage, discards in-flight fetches on a redirect, and reports misaligned fetch addresses.

---
 rtl/inst_fetch.sv | 200 ++++++++++++++++++++
 tb/tb_inst_fetch.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - instruction fetch stage with decode slot, skid entry and redirect handling
module inst_fetch (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] PC,
  input  logic        flush,
  output logic        pc_stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc,
  output logic [31:0] id_plus4,
  output logic        id_fault
);

  typedef enum logic [2:0] {
    S_ADDR,
    S_WAIT,
    S_FULL,
    S_DROP,
    S_FAULT
  } state_t;

  state_t      state_q;
  state_t      state_d;

  logic [31:0] addr_q;

  logic        sk_valid;
  logic [31:0] sk_inst;
  logic [31:0] sk_pc;
  logic [31:0] sk_plus4;
  logic        sk_fault;

  logic        slot_free;
  logic        misaligned;
  logic        latch_addr;
  logic        ld_mem;
  logic        ld_skid;
  logic        ld_fault;
  logic        mv_skid;

  // Sequential address: bit 31 is the supervisor bit and never takes a carry.
  function automatic logic [31:0] plus4(input logic [31:0] a);
    plus4 = {a[31], a[30:0] + 31'd4};
  endfunction

  assign slot_free  = !id_valid || id_ready;
  assign misaligned = (PC[1:0] != 2'b00);
  assign imem_addr  = {1'b0, addr_q[30:0]};

  // State register; reset parks in ADDR so the request drops immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_ADDR;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, memory request, PC stall and datapath load strobes.
  always_comb begin
    state_d    = state_q;
    imem_req   = 1'b0;
    pc_stall   = 1'b1;
    latch_addr = 1'b0;
    ld_mem     = 1'b0;
    ld_skid    = 1'b0;
    ld_fault   = 1'b0;
    mv_skid    = 1'b0;

    case (state_q)
      S_ADDR: begin
        latch_addr = 1'b1;
        if (misaligned && slot_free) begin
          ld_fault = 1'b1;
          state_d  = S_FAULT;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          if (slot_free) begin
            ld_mem   = 1'b1;
            pc_stall = 1'b0;
            state_d  = S_ADDR;
          end else begin
            ld_skid = 1'b1;
            state_d = S_FULL;
          end
        end
      end
      S_FULL: begin
        if (id_ready) begin
          mv_skid  = 1'b1;
          pc_stall = 1'b0;
          state_d  = S_ADDR;
        end
      end
      S_DROP: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          state_d = S_ADDR;
        end
      end
      S_FAULT: begin
        state_d = S_FAULT;
      end
      default: begin
        state_d = S_ADDR;
      end
    endcase

    // A redirect discards everything in flight, but an outstanding memory
    // request must still be allowed to complete before a new one is issued.
    if (flush) begin
      ld_mem   = 1'b0;
      ld_skid  = 1'b0;
      ld_fault = 1'b0;
      mv_skid  = 1'b0;
      if ((state_q == S_WAIT || state_q == S_DROP) && !imem_ack) begin
        state_d = S_DROP;
      end else begin
        state_d = S_ADDR;
      end
    end

    if (!reset) begin
      pc_stall = 1'b1;
    end
  end

  // Fetch address latch, decode slot and skid entry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q   <= 32'h0;
      id_valid <= 1'b0;
      id_inst  <= 32'h0;
      id_pc    <= 32'h0;
      id_plus4 <= 32'h0;
      id_fault <= 1'b0;
      sk_valid <= 1'b0;
      sk_inst  <= 32'h0;
      sk_pc    <= 32'h0;
      sk_plus4 <= 32'h0;
      sk_fault <= 1'b0;
    end else begin
      if (latch_addr) begin
        addr_q <= PC;
      end

      if (flush) begin
        id_valid <= 1'b0;
      end else if (ld_mem || ld_fault || mv_skid) begin
        id_valid <= 1'b1;
      end else if (id_ready) begin
        id_valid <= 1'b0;
      end

      if (ld_mem) begin
        id_inst  <= imem_rdata;
        id_pc    <= addr_q;
        id_plus4 <= plus4(addr_q);
        id_fault <= 1'b0;
      end else if (ld_fault) begin
        id_inst  <= 32'h0;
        id_pc    <= PC;
        id_plus4 <= plus4(PC);
        id_fault <= 1'b1;
      end else if (mv_skid) begin
        id_inst  <= sk_inst;
        id_pc    <= sk_pc;
        id_plus4 <= sk_plus4;
        id_fault <= sk_fault;
      end

      if (flush) begin
        sk_valid <= 1'b0;
      end else if (ld_skid) begin
        sk_valid <= 1'b1;
      end else if (mv_skid) begin
        sk_valid <= 1'b0;
      end

      if (ld_skid) begin
        sk_inst  <= imem_rdata;
        sk_pc    <= addr_q;
        sk_plus4 <= plus4(addr_q);
        sk_fault <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// tb/tb_inst_fetch.sv - directed self-checking bench for inst_fetch
module tb_inst_fetch;

  logic        clk;
  logic        reset;
  logic [31:0] PC;
  logic        flush;
  logic        pc_stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
  logic [31:0] id_plus4;
  logic        id_fault;

  logic [31:0] tgt;
  int          total;
  int          bad;

  inst_fetch dut (
    .clk        (clk),
    .reset      (reset),
    .PC         (PC),
    .flush      (flush),
    .pc_stall   (pc_stall),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .id_valid   (id_valid),
    .id_ready   (id_ready),
    .id_inst    (id_inst),
    .id_pc      (id_pc),
    .id_plus4   (id_plus4),
    .id_fault   (id_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock; the bench acts as the PC stage (flush target, else advance when not stalled).
  task automatic tick();
    logic st;
    logic fl;
    st = pc_stall;
    fl = flush;
    @(posedge clk);
    #1;
    if (fl) PC = tgt;
    else if (!st) PC = PC + 32'd4;
  endtask

  // Starts in ADDR; nwait cycles without ack, then one ack cycle with data.
  task automatic fetch(input int nwait, input logic [31:0] addr, input logic [31:0] data,
                       input logic exp_stall);
    chk("addr_req", imem_req, 0);
    chk("addr_stall", pc_stall, 1);
    tick();
    for (int i = 0; i < nwait; i++) begin
      chk("wait_req", imem_req, 1);
      chk("wait_addr", imem_addr, addr);
      chk("wait_stall", pc_stall, 1);
      tick();
    end
    chk("ack_req", imem_req, 1);
    chk("ack_addr", imem_addr, addr);
    imem_ack   = 1'b1;
    imem_rdata = data;
    #1;
    chk("ack_stall", pc_stall, exp_stall);
    tick();
    imem_ack = 1'b0;
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    reset      = 1'b0;
    PC         = 32'h0;
    flush      = 1'b0;
    tgt        = 32'h0;
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    id_ready   = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;

    // reset state
    chk("rst_stall", pc_stall, 1);
    chk("rst_req", imem_req, 0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", id_valid, 0);
    chk("rst_inst", id_inst, 32'h0);
    chk("rst_pc", id_pc, 32'h0);
    chk("rst_plus4", id_plus4, 32'h0);
    chk("rst_fault", id_fault, 0);
    reset = 1'b1;

    // sequential fetch, zero-wait memory
    fetch(0, 32'h0, 32'h11110000, 0);
    chk("seq0_valid", id_valid, 1);
    chk("seq0_inst", id_inst, 32'h11110000);
    chk("seq0_pc", id_pc, 32'h0);
    chk("seq0_plus4", id_plus4, 32'h4);
    fetch(0, 32'h4, 32'h22220004, 0);
    chk("seq1_inst", id_inst, 32'h22220004);
    chk("seq1_pc", id_pc, 32'h4);
    chk("seq1_plus4", id_plus4, 32'h8);
    fetch(0, 32'h8, 32'h33330008, 0);
    chk("seq2_inst", id_inst, 32'h33330008);
    chk("seq2_pc", id_pc, 32'h8);

    // three wait states
    fetch(3, 32'hC, 32'h4444000C, 0);
    chk("ws_inst", id_inst, 32'h4444000C);
    chk("ws_pc", id_pc, 32'hC);

    // backpressure: second word goes to the skid entry
    id_ready = 1'b0;
    fetch(0, 32'h10, 32'h55550010, 1);
    for (int i = 0; i < 2; i++) begin
      chk("bp_hold_inst", id_inst, 32'h4444000C);
      chk("bp_hold_pc", id_pc, 32'hC);
      chk("bp_no_req", imem_req, 0);
      chk("bp_stall", pc_stall, 1);
      chk("bp_pc_held", PC, 32'h10);
      tick();
    end
    id_ready = 1'b1;
    #1;
    chk("bp_release_stall", pc_stall, 0);
    tick();
    chk("bp_skid_valid", id_valid, 1);
    chk("bp_skid_inst", id_inst, 32'h55550010);
    chk("bp_skid_pc", id_pc, 32'h10);
    chk("bp_skid_plus4", id_plus4, 32'h14);

    // redirect in the second wait cycle
    tick();
    chk("rd_req", imem_req, 1);
    chk("rd_addr", imem_addr, 32'h14);
    tick();
    flush = 1'b1;
    tgt   = 32'h80000004;
    tick();
    flush = 1'b0;
    chk("rd_drop_req", imem_req, 1);
    chk("rd_drop_addr", imem_addr, 32'h14);
    chk("rd_drop_valid", id_valid, 0);
    chk("rd_drop_stall", pc_stall, 1);
    tick();
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEADBEEF;
    #1;
    chk("rd_ack_stall", pc_stall, 1);
    tick();
    imem_ack = 1'b0;
    chk("rd_after_valid", id_valid, 0);
    chk("rd_no_deadbeef", (id_inst == 32'hDEADBEEF), 0);
    fetch(0, 32'h00000004, 32'h66660004, 0);
    chk("rd_new_inst", id_inst, 32'h66660004);
    chk("rd_new_pc", id_pc, 32'h80000004);
    chk("rd_new_plus4", id_plus4, 32'h80000008);

    // late redirect coinciding with ack
    tick();
    imem_ack   = 1'b1;
    imem_rdata = 32'h77777777;
    flush      = 1'b1;
    tgt        = 32'h100;
    tick();
    imem_ack = 1'b0;
    flush    = 1'b0;
    chk("late_req", imem_req, 0);
    chk("late_valid", id_valid, 0);

    // misaligned fetch
    flush = 1'b1;
    tgt   = 32'h6;
    tick();
    flush = 1'b0;
    chk("mis_addr_req", imem_req, 0);
    tick();
    chk("mis_valid", id_valid, 1);
    chk("mis_fault", id_fault, 1);
    chk("mis_inst", id_inst, 32'h0);
    chk("mis_pc", id_pc, 32'h6);
    chk("mis_plus4", id_plus4, 32'hA);
    for (int i = 0; i < 3; i++) begin
      chk("mis_no_req", imem_req, 0);
      chk("mis_stall", pc_stall, 1);
      tick();
    end

    // supervisor wrap
    flush = 1'b1;
    tgt   = 32'hFFFFFFFC;
    tick();
    flush = 1'b0;
    fetch(0, 32'h7FFFFFFC, 32'h88888888, 0);
    chk("sup_pc", id_pc, 32'hFFFFFFFC);
    chk("sup_plus4", id_plus4, 32'h80000000);
    chk("sup_fault", id_fault, 0);

    // reset mid-transaction
    tick();
    chk("mid_req", imem_req, 1);
    reset = 1'b0;
    #1;
    chk("mid_rst_req", imem_req, 0);
    chk("mid_rst_stall", pc_stall, 1);
    chk("mid_rst_valid", id_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
